demux1to8by32_hs: RTL and testbench

Handshaked 1-to-NUM_OUT data distributor: routes one WIDTH-bit word from a single producer to one of NUM_OUT consumers selected by a per-word address. Functionally inverse to the 8-to-1 by-32 select path. Used on the FPU result write-back path, where one result stream fans out to several destination units or register banks. Output is registered and backed by a 2-entry skid stage, giving full throughput with one-cycle latency; word order is preserved.

---
 rtl/demux1to8by32_hs_pkg.sv | 20 ++
 rtl/hs_skid_reg.sv | 54 +++++
 rtl/demux1to8by32_hs.sv | 75 +++++++
 tb/tb_demux1to8by32_hs.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux1to8by32_hs_pkg.sv
// Shared defaults and helpers for the handshaked 1-to-N word distributor.
// Port masks are sized for the largest supported fan-out and then sliced by users.
package demux1to8by32_hs_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_OUT = 8;
  localparam int DEF_ADDR_W  = 3;
  localparam int MAX_OUT     = 8;

  // One-hot mask for a destination index; indices beyond MAX_OUT give all zeros.
  function automatic logic [MAX_OUT-1:0] port_mask(input int addr);
    logic [MAX_OUT-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      m[i] = (addr == i);
    end
    return m;
  endfunction

endpackage

// File: rtl/hs_skid_reg.sv
// Generic two-entry skid register: head entry drives the consumer, skid entry absorbs
// one word when the head stalls. push_ready depends only on registered state.
module hs_skid_reg #(
  parameter int DW = 35
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [DW-1:0] pop_data
);

  logic          h_valid;
  logic          s_valid;
  logic [DW-1:0] h_data;
  logic [DW-1:0] s_data;
  logic          take;

  assign push_ready = ~s_valid;
  assign take       = push_valid & ~s_valid;
  assign pop_valid  = h_valid;
  assign pop_data   = h_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
      h_data  <= '0;
      s_data  <= '0;
    end else if (!h_valid || pop_ready) begin
      // Head is free this cycle: the older skid word always goes first.
      if (s_valid) begin
        h_valid <= 1'b1;
        h_data  <= s_data;
        s_valid <= take;
        if (take) begin
          s_data <= push_data;
        end
      end else if (take) begin
        h_valid <= 1'b1;
        h_data  <= push_data;
      end else begin
        h_valid <= 1'b0;
      end
    end else if (take) begin
      s_valid <= 1'b1;
      s_data  <= push_data;
    end
  end

endmodule

// File: rtl/demux1to8by32_hs.sv
// Handshaked 1-to-NUM_OUT distributor: one producer stream fanned out to the port named
// by each word's address, in strict order, with one-cycle latency and full throughput.
module demux1to8by32_hs
  import demux1to8by32_hs_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [WIDTH-1:0]   in_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               drop_err
);

  localparam int EW = ADDR_W + WIDTH;

  logic               acc;
  logic               addr_ok;
  logic               push;
  logic               push_ready;
  logic               fire;
  logic               h_valid;
  logic [EW-1:0]      head_word;
  logic [ADDR_W-1:0]  h_addr;
  logic [MAX_OUT-1:0] head_mask;

  assign addr_ok  = int'(in_addr) < NUM_OUT;
  assign in_ready = push_ready;
  assign acc      = in_valid & push_ready;
  // Out-of-range words complete the handshake but are never stored.
  assign push     = acc & addr_ok;

  hs_skid_reg #(
    .DW(EW)
  ) u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_valid (push),
    .push_ready (push_ready),
    .push_data  ({in_addr, in_data}),
    .pop_valid  (h_valid),
    .pop_ready  (fire),
    .pop_data   (head_word)
  );

  assign h_addr    = head_word[EW-1:WIDTH];
  assign out_data  = head_word[WIDTH-1:0];
  assign head_mask = port_mask(int'(h_addr));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_port
      assign out_valid[gi] = h_valid & head_mask[gi];
    end
  endgenerate

  // Only the addressed consumer can advance the head.
  assign fire = |(out_valid & out_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_err <= 1'b0;
    end else begin
      drop_err <= acc & ~addr_ok;
    end
  end

endmodule

// File: tb/tb_demux1to8by32_hs.sv
// Bench for the 1-to-N distributor: an 8-port and a 6-port instance, each checked every
// cycle against a 2-deep FIFO model, plus directed sequences with literal expectations.
module tb_demux1to8by32_hs;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       iv;
  logic [1:0]       ir;
  logic [1:0]       de;
  logic [1:0][2:0]  ia;
  logic [1:0][31:0] id;
  logic [1:0][31:0] od;
  logic [1:0][7:0]  ordy;
  logic [7:0]       ov8;
  logic [5:0]       ov6;

  int n_vec = 0;
  int n_bad = 0;

  demux1to8by32_hs #(.WIDTH(32), .NUM_OUT(8), .ADDR_W(3)) dut8 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_addr(ia[0]), .in_data(id[0]),
    .out_valid(ov8), .out_ready(ordy[0]), .out_data(od[0]), .drop_err(de[0])
  );

  demux1to8by32_hs #(.WIDTH(32), .NUM_OUT(6), .ADDR_W(3)) dut6 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_addr(ia[1]), .in_data(id[1]),
    .out_valid(ov6), .out_ready(ordy[1][5:0]), .out_data(od[1]), .drop_err(de[1])
  );

  // Model: each instance is a FIFO of capacity two; the front word is what is presented.
  int          mcnt[2];
  logic [2:0]  ma[2][2];
  logic [31:0] md[2][2];
  logic        mdrop[2];
  logic        mzero[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ov_of(input int d);
    return (d == 0) ? ov8 : {2'b00, ov6};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d]  = 0;
      mdrop[d] = 1'b0;
      mzero[d] = 1'b1;
    end
  endtask

  task automatic model_step(input int d);
    int nout;
    bit acc;
    bit fire;
    nout = (d == 0) ? 8 : 6;
    acc  = iv[d] && (mcnt[d] < 2);
    fire = (mcnt[d] > 0) && ordy[d][ma[d][0]];
    if (fire) begin
      ma[d][0] = ma[d][1];
      md[d][0] = md[d][1];
      mcnt[d]--;
    end
    mdrop[d] = acc && (int'(ia[d]) >= nout);
    if (acc && (int'(ia[d]) < nout)) begin
      ma[d][mcnt[d]] = ia[d];
      md[d][mcnt[d]] = id[d];
      mcnt[d]++;
      mzero[d] = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  // Compare process: every falling edge, both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset_n) chk($sformatf("m%0d in_ready", d), {31'd0, ir[d]}, {31'd0, mcnt[d] < 2});
        chk($sformatf("m%0d out_valid", d), {24'd0, ov_of(d)},
            (mcnt[d] > 0) ? (32'd1 << ma[d][0]) : 32'd0);
        chk($sformatf("m%0d drop_err", d), {31'd0, de[d]}, {31'd0, mdrop[d]});
        if (mcnt[d] > 0) chk($sformatf("m%0d out_data", d), od[d], md[d][0]);
        else if (mzero[d]) chk($sformatf("m%0d out_data_rst", d), od[d], 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    iv   = '0;
    ia   = '0;
    id   = '0;
    ordy = {8'hFF, 8'hFF};

    // Reset and release
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst in_ready", {31'd0, ir[0]}, 32'd1);
    chk("rst out_valid", {24'd0, ov8}, 32'd0);
    chk("rst out_data", od[0], 32'd0);

    // Streaming to every port back-to-back
    for (int a = 0; a < 8; a++) begin
      iv[0] = 1'b1;
      ia[0] = 3'(a);
      id[0] = 32'hA0 + 32'(a);
      tick();
      chk($sformatf("stream%0d valid", a), {24'd0, ov8}, 32'd1 << a);
      chk($sformatf("stream%0d data", a), od[0], 32'hA0 + 32'(a));
      chk($sformatf("stream%0d ready", a), {31'd0, ir[0]}, 32'd1);
    end
    iv[0] = 1'b0;
    tick();
    chk("stream drain", {24'd0, ov8}, 32'd0);

    // Backpressure on port 3
    ordy[0] = 8'hF7;
    iv[0] = 1'b1; ia[0] = 3'd3; id[0] = 32'h1111;
    tick();
    chk("bp w1 valid", {24'd0, ov8}, 32'h08);
    ia[0] = 3'd5; id[0] = 32'h2222;
    tick();
    chk("bp full ready", {31'd0, ir[0]}, 32'd0);
    ia[0] = 3'd6; id[0] = 32'h3333;
    tick();
    chk("bp stall ready", {31'd0, ir[0]}, 32'd0);
    chk("bp stall valid", {24'd0, ov8}, 32'h08);
    chk("bp stall data", od[0], 32'h1111);
    ordy[0] = 8'hFF;
    tick();
    chk("bp w2 valid", {24'd0, ov8}, 32'h20);
    chk("bp w2 data", od[0], 32'h2222);
    chk("bp ready back", {31'd0, ir[0]}, 32'd1);
    tick();
    chk("bp w3 valid", {24'd0, ov8}, 32'h40);
    chk("bp w3 data", od[0], 32'h3333);
    iv[0] = 1'b0;
    tick();

    // Ready on other ports must not advance a head addressed to port 2
    ordy[0] = 8'hFB;
    iv[0] = 1'b1; ia[0] = 3'd2; id[0] = 32'hCAFE;
    tick();
    iv[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("iso valid", {24'd0, ov8}, 32'h04);
      chk("iso data", od[0], 32'hCAFE);
    end
    ordy[0] = 8'hFF;
    tick();
    chk("iso release", {24'd0, ov8}, 32'd0);

    // Asynchronous reset with both entries full
    ordy[0] = 8'h00;
    iv[0] = 1'b1; ia[0] = 3'd1; id[0] = 32'h11;
    tick();
    ia[0] = 3'd2; id[0] = 32'h22;
    tick();
    iv[0] = 1'b0;
    chk("full ready", {31'd0, ir[0]}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid rst valid", {24'd0, ov8}, 32'd0);
    chk("mid rst data", od[0], 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    ordy[0] = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post rst ready", {31'd0, ir[0]}, 32'd1);
      chk("post rst no stale", {24'd0, ov8}, 32'd0);
    end

    // Out-of-range address on the 6-port instance
    iv[1] = 1'b1; ia[1] = 3'd1; id[1] = 32'h0101;
    tick();
    chk("drop w1 valid", {26'd0, ov6}, 32'h02);
    chk("drop w1 err", {31'd0, de[1]}, 32'd0);
    ia[1] = 3'd7; id[1] = 32'hDEAD;
    tick();
    chk("drop pulse", {31'd0, de[1]}, 32'd1);
    chk("drop not presented", {26'd0, ov6}, 32'd0);
    ia[1] = 3'd4; id[1] = 32'h0404;
    tick();
    chk("drop w3 valid", {26'd0, ov6}, 32'h10);
    chk("drop w3 data", od[1], 32'h0404);
    chk("drop pulse end", {31'd0, de[1]}, 32'd0);
    iv[1] = 1'b0;
    tick();
    chk("drop idle", {26'd0, ov6}, 32'd0);

    // Random valid/ready traffic on both instances, model-checked every cycle
    for (int c = 0; c < 1000; c++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d]   = ($urandom_range(0, 3) != 0);
        ia[d]   = 3'($urandom_range(0, 7));
        id[d]   = $urandom;
        ordy[d] = 8'($urandom) | 8'($urandom);
      end
      if (c == 500) reset_n = 1'b0;
      if (c == 502) reset_n = 1'b1;
      tick();
    end
    iv = '0;
    ordy = {8'hFF, 8'hFF};
    repeat (4) tick();
    chk("final empty 8", {24'd0, ov8}, 32'd0);
    chk("final empty 6", {26'd0, ov6}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
